// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the instruction-fetch stage.
// Imported by the interface, the program counter and the fetch stage top.
package fetch_stage_pkg;

    localparam int          INSTR_WIDTH      = 32;
    localparam int          JIDX_WIDTH       = 26;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    // J-format target keeps the top nibble of the sequential PC and word-aligns the index.
    function automatic logic [31:0] jumpTarget(input logic [31:0] pcPlus4,
                                               input logic [JIDX_WIDTH-1:0] jumpIndex);
        return {pcPlus4[31:28], jumpIndex, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Control, instruction-memory and IF/ID bundle of the fetch stage.
// The fetch stage takes the slave view; whatever drives the stage takes the master view.
interface fetch_stage_if;
    import fetch_stage_pkg::*;

    logic                   stall;
    logic                   flush;
    logic                   branch_taken;
    logic [31:0]            branch_target;
    logic                   jump;
    logic [JIDX_WIDTH-1:0]  jump_index;
    logic [INSTR_WIDTH-1:0] instr_in;
    logic [31:0]            instr_address;
    logic [INSTR_WIDTH-1:0] ifid_instruction;
    logic [31:0]            ifid_pcplus4;
    logic                   ifid_valid;
    logic [31:0]            fetch_count;
    logic                   wrap_flag;

    modport master (
        output stall, flush, branch_taken, branch_target, jump, jump_index, instr_in,
        input  instr_address, ifid_instruction, ifid_pcplus4, ifid_valid, fetch_count, wrap_flag
    );

    modport slave (
        input  stall, flush, branch_taken, branch_target, jump, jump_index, instr_in,
        output instr_address, ifid_instruction, ifid_pcplus4, ifid_valid, fetch_count, wrap_flag
    );

endinterface

// File: rtl/fetch_stage_program_counter.sv
// PC register with its next-PC selection: reset, then redirect (jump over branch), then stall, else +4.
// Also reports whether this edge is a redirect or a plain sequential advance.
module program_counter
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  jump,
    input  logic                  branch_taken,
    input  logic [31:0]           branch_target,
    input  logic [JIDX_WIDTH-1:0] jump_index,
    output logic [31:0]           pc,
    output logic [31:0]           pc_plus4,
    output logic                  redirect,
    output logic                  advance
);

    logic [31:0] target;

    assign pc_plus4 = pc + 32'd4;
    assign redirect = jump | branch_taken;
    assign advance  = !reset && !redirect && !stall;

    // Branch targets are forced word-aligned; jump outranks branch.
    always_comb begin
        target = {branch_target[31:2], 2'b00};
        if (jump) begin
            target = jumpTarget(pc_plus4, jump_index);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (redirect) begin
            pc <= target;
        end else if (!stall) begin
            pc <= pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: drives the external instruction memory from the PC and registers
// the returned word into IF/ID, counting delivered instructions and flagging PC wrap-around.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
    parameter int          IMEM_WORDS = 128
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.slave  bus
);

    // IMEM_WORDS is expected to be a power of two (at least 2) so the word index is a bit field.
    localparam int                  IDX_BITS = $clog2(IMEM_WORDS);
    localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(IMEM_WORDS - 1);

    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        redirect;
    logic        advance;
    logic        loadValid;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk           (clk),
        .reset         (reset),
        .stall         (bus.stall),
        .jump          (bus.jump),
        .branch_taken  (bus.branch_taken),
        .branch_target (bus.branch_target),
        .jump_index    (bus.jump_index),
        .pc            (pc),
        .pc_plus4      (pcPlus4),
        .redirect      (redirect),
        .advance       (advance)
    );

    assign bus.instr_address = pc;
    assign loadValid         = !redirect && !bus.flush && !bus.stall;

    // Redirect squashes the wrong-path word fetched this cycle; there is no delay slot.
    always_ff @(posedge clk) begin
        if (reset || bus.flush || redirect) begin
            bus.ifid_instruction <= NOP_INSTR;
            bus.ifid_pcplus4     <= 32'h0;
            bus.ifid_valid       <= 1'b0;
        end else if (!bus.stall) begin
            bus.ifid_instruction <= bus.instr_in;
            bus.ifid_pcplus4     <= pcPlus4;
            bus.ifid_valid       <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.fetch_count <= 32'h0;
        end else if (loadValid && bus.fetch_count != 32'hFFFF_FFFF) begin
            bus.fetch_count <= bus.fetch_count + 32'd1;
        end
    end

    // Only a sequential step off the last memory word counts as a wrap, never a redirect.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.wrap_flag <= 1'b0;
        end else if (advance && pc[IDX_BITS+1:2] == LAST_IDX) begin
            bus.wrap_flag <= 1'b1;
        end
    end

endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter IMEM_WORDS, default 128: instruction-memory depth in words; used only for the wrap flag.
REQ-003 Clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Reset  input  1: reset is synchronous and active-high.
REQ-005 Stall  input  1: hazard stall; hold PC and hold the IF/ID register.
REQ-006 Flush  input  1: replace the IF/ID contents with a bubble.
REQ-007 BranchTaken  input  1: redirect to BranchTarget.
REQ-008 BranchTarget  input  32: branch destination byte address.
REQ-009 Jump  input  1: redirect to the jump target.
REQ-010 JumpIndex  input  26: J-format target field.
REQ-011 InstrIn  input  32: word returned combinationally by instruction memory for InstrAddress.
REQ-012 InstrAddress  output  32: current PC, driven to the instruction-memory address port.
REQ-013 IFID_Instruction  output  32: registered fetched instruction.
REQ-014 IFID_PCPlus4  output  32: registered PC+4 of that instruction.
REQ-015 IFID_Valid  output  1: 1 = real instruction, 0 = bubble.
REQ-016 FetchCount  output  32: count of valid instructions delivered to IF/ID.
REQ-017 WrapFlag  output  1: sticky flag, PC word index passed IMEM_WORDS-1.

Function
REQ-018 InstrAddress SHALL equal the PC register directly, with no combinational path from any input.
REQ-019 Redirect target priority SHALL be Jump > BranchTaken.
REQ-020 The jump target SHALL be {PC+4[31:28], JumpIndex, 2'b00}.
REQ-021 The branch target SHALL be {BranchTarget[31:2], 2'b00}, so bits [1:0] are always forced to zero.
REQ-022 PC next-state priority per edge SHALL be, in order: Reset -> RESET_PC; redirect -> target; Stall -> hold; otherwise PC+4 with modulo-2^32 wrap.
REQ-023 The IF/ID register SHALL update each edge with this priority:
- Reset or Flush or redirect -> bubble (Instruction 32'h0, PCPlus4 32'h0, Valid 0);
- else Stall -> hold all three fields;
- else capture InstrIn, PC+4, Valid 1.
REQ-024 Redirect concurrent with Stall SHALL take the redirect and insert a bubble; the stall is ignored for that edge.
REQ-025 There is no branch delay slot: the wrong-path instruction fetched in the redirect cycle SHALL NOT reach IF/ID.
REQ-026 Fetch latency SHALL be one cycle: the word at PC appears on IFID_Instruction after the next rising edge.
REQ-027 FetchCount SHALL increment by 1 on each edge where IF/ID loads with Valid=1.
- It saturates at 32'hFFFF_FFFF.
- A held (stalled) entry SHALL NOT count again.
REQ-028 WrapFlag SHALL set when PC advances by +4 from word index IMEM_WORDS-1 (0x1FC for 128 words), i.e. PC[8:2] wraps from 127 to 0.
- It stays set until Reset.
- Redirects never set it.

Reset
REQ-029 On Reset the block SHALL drive: PC = RESET_PC, IFID_Instruction = 0, IFID_PCPlus4 = 0, IFID_Valid = 0, FetchCount = 0, WrapFlag = 0.
REQ-030 Reset SHALL override Stall, Flush and redirect in the same cycle.
REQ-031 Reset asserted mid-stall or mid-redirect SHALL discard all pending state; the first valid fetch after deassertion SHALL be at RESET_PC.

Structure
REQ-032 A shared package SHALL hold NOP_INSTR (32'h0), DEFAULT_RESET_PC, INSTR_WIDTH (32) and JIDX_WIDTH (26).
REQ-033 PC register plus next-PC mux SHALL be one sub-module, program_counter; the IF/ID register, counter and flag stay in fetch_stage.
REQ-034 The block SHALL contain no memory array; instruction memory remains external.

Verification
REQ-035 Reset, then 4 free-running cycles with InstrIn = 32'h2008_0000 -> InstrAddress steps 0, 4, 8, 12; FetchCount = 4; IFID_PCPlus4 = 16.
REQ-036 Stall held 3 cycles at PC = 8 -> PC and IF/ID frozen; FetchCount unchanged; on release, next capture has IFID_PCPlus4 = 12.
REQ-037 Jump with JumpIndex = 1 at PC = 0xF4 -> next PC = 0x4; IF/ID is a bubble that cycle; Valid = 1 again the following cycle.
REQ-038 BranchTaken, BranchTarget = 0x4B, and Jump all asserted together with Stall -> jump wins; BranchTarget is not used; Stall ignored; bubble inserted.
REQ-039 Free-run from 0x1F8 -> PC goes 0x1FC, then 0x200; WrapFlag rises on the edge producing 0x200.
REQ-040 Reset asserted during a Flush+Stall cycle with FetchCount = 7 -> all outputs take their reset values next edge; first post-reset InstrAddress = RESET_PC.
